// File: rtl/hack_pkg.sv
// Shared constants, FSM state encoding and byte helpers for the Hack instruction ROM loader.
package hack_pkg;

    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned DEPTH      = 32768;
    localparam logic [15:0] FILL_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        CK_HI,
        CK_LO,
        RUN,
        ERR
    } state_t;

    // Stream fields arrive big-endian: the byte held from the previous transfer is the high half.
    function automatic logic [15:0] be_word(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/hack_rom.sv
// Instruction store: one synchronous write port from the loader, one asynchronous read port for the CPU.
module hack_rom #(
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned DEPTH  = 32768
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader for the Hack CPU: fills the ROM from a framed byte stream (N, N words, checksum),
// verifies the checksum and only then releases the CPU via cpu_run.
module hack_rom_loader #(
    parameter int unsigned ADDR_W     = hack_pkg::ADDR_W,
    parameter int unsigned DEPTH      = hack_pkg::DEPTH,
    parameter logic [15:0] FILL_INSTR = hack_pkg::FILL_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    input  logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr,
    output logic              cpu_run,
    output logic              load_done,
    output logic              err
);

    import hack_pkg::*;

    // One extra bit so a count of DEPTH words is representable without wrapping.
    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t           state_q;
    logic             rx_ready_q;
    logic             cpu_run_q;
    logic             load_done_q;
    logic             err_q;
    logic [7:0]       hi_q;
    logic [CNT_W-1:0] nlen_q;
    logic [CNT_W-1:0] waddr_q;
    logic [CNT_W-1:0] nwords_q;
    logic [15:0]      csum_q;

    logic             xfer;
    logic             rom_we;
    logic [15:0]      word_d;
    logic [15:0]      csum_d;
    logic [15:0]      rom_rdata;

    assign xfer   = rx_valid & rx_ready_q;
    assign word_d = be_word(hi_q, rx_data);
    assign csum_d = csum_q + word_d;
    assign rom_we = xfer & ~reload & (state_q == DAT_LO);

    hack_rom #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_rom (
        .clk   (clk),
        .we    (rom_we),
        .waddr (waddr_q[ADDR_W-1:0]),
        .wdata (word_d),
        .raddr (pc),
        .rdata (rom_rdata)
    );

    // nwords only moves on entry to RUN, so words from a partial or failed load stay hidden.
    always_comb begin
        instr = FILL_INSTR;
        if ({1'b0, pc} < nwords_q) begin
            instr = rom_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HDR_HI;
            rx_ready_q  <= 1'b0;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            nlen_q      <= '0;
            waddr_q     <= '0;
            nwords_q    <= '0;
            csum_q      <= '0;
        end else if (reload) begin
            state_q     <= HDR_HI;
            rx_ready_q  <= 1'b1;
            cpu_run_q   <= 1'b0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            nlen_q      <= '0;
            waddr_q     <= '0;
            nwords_q    <= '0;
            csum_q      <= '0;
        end else begin
            if (state_q != RUN && state_q != ERR) begin
                rx_ready_q <= 1'b1;
            end
            if (xfer) begin
                case (state_q)
                    HDR_HI: begin
                        hi_q    <= rx_data;
                        state_q <= HDR_LO;
                    end
                    HDR_LO: begin
                        if (word_d == 16'h0000 || {16'h0000, word_d} > DEPTH) begin
                            state_q    <= ERR;
                            err_q      <= 1'b1;
                            rx_ready_q <= 1'b0;
                        end else begin
                            nlen_q  <= CNT_W'(word_d);
                            state_q <= DAT_HI;
                        end
                    end
                    DAT_HI: begin
                        hi_q    <= rx_data;
                        state_q <= DAT_LO;
                    end
                    DAT_LO: begin
                        csum_q  <= csum_d;
                        waddr_q <= waddr_q + CNT_W'(1);
                        if (waddr_q == nlen_q - CNT_W'(1)) begin
                            state_q <= CK_HI;
                        end else begin
                            state_q <= DAT_HI;
                        end
                    end
                    CK_HI: begin
                        hi_q    <= rx_data;
                        state_q <= CK_LO;
                    end
                    CK_LO: begin
                        rx_ready_q <= 1'b0;
                        if (word_d == csum_q) begin
                            state_q     <= RUN;
                            cpu_run_q   <= 1'b1;
                            load_done_q <= 1'b1;
                            nwords_q    <= nlen_q;
                        end else begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready  = rx_ready_q;
    assign cpu_run   = cpu_run_q;
    assign load_done = load_done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: good/bad frames, header limits, reload and async reset.
module tb_hack_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        reload;
    logic [14:0] pc;
    logic [15:0] instr;
    logic        cpu_run;
    logic        load_done;
    logic        err;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] frm[$];

    hack_rom_loader #(
        .ADDR_W     (15),
        .DEPTH      (32768),
        .FILL_INSTR (16'h0000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .reload    (reload),
        .pc        (pc),
        .instr     (instr),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic done;
        done     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (rx_ready) begin
                done = 1'b1;
            end
            step();
        end
        if (!done) begin
            check("byte_accept_timeout", {31'b0, done}, 32'd1);
        end
    endtask

    task automatic send_frame();
        foreach (frm[i]) begin
            send_byte(frm[i]);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    task automatic check_pc(input string tag, input logic [14:0] addr, input logic [15:0] exp);
        pc = addr;
        #1;
        check(tag, {16'h0, instr}, {16'h0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reload   = 1'b0;
        pc       = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("rst_load_done", {31'b0, load_done}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_instr", {16'h0, instr}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_rx_ready_before_edge", {31'b0, rx_ready}, 32'd0);
        step();
        check("rel_rx_ready_after_edge", {31'b0, rx_ready}, 32'd1);

        // Test 1: good 2-word frame
        frm = {8'h00, 8'h02, 8'h00, 8'h05, 8'hEA, 8'h87, 8'hEA, 8'h8C};
        send_frame();
        check("t1_cpu_run", {31'b0, cpu_run}, 32'd1);
        check("t1_load_done", {31'b0, load_done}, 32'd1);
        check("t1_err", {31'b0, err}, 32'd0);
        check("t1_rx_ready", {31'b0, rx_ready}, 32'd0);
        check_pc("t1_pc0", 15'd0, 16'h0005);
        check_pc("t1_pc1", 15'd1, 16'hEA87);
        check_pc("t1_pc2", 15'd2, 16'h0000);
        step();

        // Test 4: random rx_valid activity while running must not be consumed
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            check("t4_rx_ready_run", {31'b0, rx_ready}, 32'd0);
            step();
        end
        rx_valid = 1'b0;
        check("t4_load_done", {31'b0, load_done}, 32'd1);
        check_pc("t4_pc0", 15'd0, 16'h0005);
        check_pc("t4_pc1", 15'd1, 16'hEA87);
        check_pc("t4_pc2", 15'd2, 16'h0000);
        step();

        // Test 2: checksum mismatch
        pulse_reload();
        check("t2_reload_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("t2_reload_load_done", {31'b0, load_done}, 32'd0);
        check("t2_reload_rx_ready", {31'b0, rx_ready}, 32'd1);
        check_pc("t2_reload_pc0", 15'd0, 16'h0000);
        step();
        frm = {8'h00, 8'h02, 8'h00, 8'h05, 8'hEA, 8'h87, 8'hEA, 8'h8B};
        send_frame();
        check("t2_err", {31'b0, err}, 32'd1);
        check("t2_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("t2_load_done", {31'b0, load_done}, 32'd0);
        check("t2_rx_ready", {31'b0, rx_ready}, 32'd0);
        check_pc("t2_pc0", 15'd0, 16'h0000);
        check_pc("t2_pc1", 15'd1, 16'h0000);
        check_pc("t2_pc2", 15'd2, 16'h0000);
        step();

        // Test 3: header length limits
        pulse_reload();
        check("t3_reload_err_clear", {31'b0, err}, 32'd0);
        frm = {8'h00, 8'h00};
        send_frame();
        check("t3_n0_err", {31'b0, err}, 32'd1);
        check("t3_n0_rx_ready", {31'b0, rx_ready}, 32'd0);
        pulse_reload();
        frm = {8'h80, 8'h01};
        send_frame();
        check("t3_n8001_err", {31'b0, err}, 32'd1);
        check("t3_n8001_rx_ready", {31'b0, rx_ready}, 32'd0);
        pulse_reload();
        frm = {8'h80, 8'h00};
        send_frame();
        check("t3_n8000_err", {31'b0, err}, 32'd0);
        check("t3_n8000_rx_ready", {31'b0, rx_ready}, 32'd1);
        pulse_reload();

        // Test 5: reload coinciding with the low byte of word 3
        frm = {8'h00, 8'h04, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44};
        send_frame();
        rx_valid = 1'b1;
        rx_data  = 8'h44;
        reload   = 1'b1;
        step();
        reload   = 1'b0;
        rx_valid = 1'b0;
        check("t5_err", {31'b0, err}, 32'd0);
        check("t5_load_done", {31'b0, load_done}, 32'd0);
        check("t5_rx_ready", {31'b0, rx_ready}, 32'd1);
        frm = {8'h00, 8'h01, 8'h12, 8'h34, 8'h12, 8'h34};
        send_frame();
        check("t5_load_done_new", {31'b0, load_done}, 32'd1);
        check("t5_err_new", {31'b0, err}, 32'd0);
        check_pc("t5_pc0", 15'd0, 16'h1234);
        check_pc("t5_pc1", 15'd1, 16'h0000);
        step();

        // Test 6: asynchronous reset mid-frame, then a full load
        pulse_reload();
        frm = {8'h00, 8'h02, 8'h00, 8'h05};
        send_frame();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_rx_ready", {31'b0, rx_ready}, 32'd0);
        check("t6_async_cpu_run", {31'b0, cpu_run}, 32'd0);
        check("t6_async_load_done", {31'b0, load_done}, 32'd0);
        check("t6_async_err", {31'b0, err}, 32'd0);
        check_pc("t6_async_pc0", 15'd0, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        check("t6_rx_ready", {31'b0, rx_ready}, 32'd1);
        frm = {8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFF, 8'hFF, 8'h00, 8'h02};
        send_frame();
        check("t6_load_done", {31'b0, load_done}, 32'd1);
        check("t6_cpu_run", {31'b0, cpu_run}, 32'd1);
        check("t6_err", {31'b0, err}, 32'd0);
        check_pc("t6_pc0", 15'd0, 16'h0001);
        check_pc("t6_pc1", 15'd1, 16'h0002);
        check_pc("t6_pc2", 15'd2, 16'hFFFF);
        check_pc("t6_pc3", 15'd3, 16'h0000);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
